pc_sequencer: RTL and testbench

Program-counter and instruction-fetch sequencer for the single-cycle MIPS core. It owns the PC register and fetches each instruction from instruction memory over a req/ack handshake. It presents the instruction to the decode/controller path for one commit cycle, then consumes the controller's `pc_control`, the ALU zero flag and the operands to compute and load the next PC. It also supplies the JAL/JALR link address.

---
 rtl/mips_pkg.sv | 19 +
 rtl/pc_target_calc.sv | 49 ++++
 rtl/pc_sequencer.sv | 110 +++++++++++
 tb/tb_pc_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: next-PC selector encodings used by the controller
// and the fetch sequencer, plus the sequencer state enum.
package mips_pkg;

  localparam logic [3:0] PC_SEQ  = 4'b0000;
  localparam logic [3:0] PC_J    = 4'b0001;
  localparam logic [3:0] PC_JR   = 4'b0010;
  localparam logic [3:0] PC_JAL  = 4'b0011;
  localparam logic [3:0] PC_JALR = 4'b0100;
  localparam logic [3:0] PC_BEQ  = 4'b0101;
  localparam logic [3:0] PC_BNE  = 4'b0110;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_RETRY = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC selection and error detection for the committing
// instruction.
module pc_target_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instr_idx,
  input  logic [3:0]  pc_control,
  input  logic        zero,
  input  logic [31:0] rs_data,
  output logic [31:0] next_pc,
  output logic        illegal,
  output logic        misalign
);

  function automatic logic signed [31:0] branch_offset(input logic [15:0] imm);
    logic signed [31:0] off;
    off = {{14{imm[15]}}, imm, 2'b00};
    return off;
  endfunction

  logic [31:0] pc4;
  logic [31:0] br_target;
  logic [31:0] jmp_target;
  logic [31:0] reg_target;

  assign pc4        = pc + 32'd4;
  assign br_target  = pc4 + $unsigned(branch_offset(instr_idx[15:0]));
  assign jmp_target = {pc4[31:28], instr_idx, 2'b00};
  assign reg_target = {rs_data[31:2], 2'b00};

  always_comb begin
    next_pc  = pc4;
    illegal  = 1'b0;
    misalign = 1'b0;
    case (pc_control)
      PC_SEQ:          next_pc = pc4;
      PC_J, PC_JAL:    next_pc = jmp_target;
      PC_JR, PC_JALR: begin
        next_pc  = reg_target;
        misalign = (rs_data[1:0] != 2'b00);
      end
      PC_BEQ:          next_pc = zero ? br_target : pc4;
      PC_BNE:          next_pc = zero ? pc4 : br_target;
      default:         illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and instruction fetch sequencer: req/ack fetch with
// timeout retry, one-cycle commit, next-PC load and sticky error flags.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic [3:0]  pc_control,
  input  logic        zero,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        illegal_err,
  output logic        misalign_err,
  output logic        fetch_timeout
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  pc_state_e        state, state_nxt;
  logic [CNT_W-1:0] to_cnt, to_cnt_nxt;
  logic             fetch_live;
  logic             fetch_done;
  logic             to_hit;
  logic [31:0]      next_pc;
  logic             calc_illegal;
  logic             calc_misalign;

  // The first cycle after reset sits in FETCH with the request still low,
  // so the FETCH work is gated on the registered request.
  assign fetch_live = (state == ST_FETCH) && imem_req;
  assign fetch_done = fetch_live && imem_ack;
  assign to_hit     = fetch_live && !imem_ack && (to_cnt == CNT_W'(ACK_TIMEOUT - 1));

  assign imem_addr = pc;
  assign link_addr = pc + 32'd4;

  pc_target_calc u_calc (
    .pc         (pc),
    .instr_idx  (instr[25:0]),
    .pc_control (pc_control),
    .zero       (zero),
    .rs_data    (rs_data),
    .next_pc    (next_pc),
    .illegal    (calc_illegal),
    .misalign   (calc_misalign)
  );

  always_comb begin
    state_nxt  = state;
    to_cnt_nxt = to_cnt;
    case (state)
      ST_FETCH: begin
        if (fetch_done) begin
          state_nxt  = ST_EXEC;
          to_cnt_nxt = '0;
        end else if (to_hit) begin
          state_nxt  = ST_RETRY;
          to_cnt_nxt = '0;
        end else if (fetch_live) begin
          to_cnt_nxt = to_cnt + 1'b1;
        end
      end
      ST_EXEC:  state_nxt = ST_FETCH;
      ST_RETRY: begin
        state_nxt  = ST_FETCH;
        to_cnt_nxt = '0;
      end
      default:  state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_FETCH;
      to_cnt        <= '0;
      imem_req      <= 1'b0;
      instr_valid   <= 1'b0;
      instr         <= '0;
      pc            <= RESET_PC;
      illegal_err   <= 1'b0;
      misalign_err  <= 1'b0;
      fetch_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      to_cnt      <= to_cnt_nxt;
      imem_req    <= (state_nxt == ST_FETCH);
      instr_valid <= fetch_done;
      if (fetch_done)
        instr <= imem_rdata;
      if (state == ST_EXEC) begin
        pc           <= next_pc;
        illegal_err  <= illegal_err | calc_illegal;
        misalign_err <= misalign_err | calc_misalign;
      end
      if (to_hit)
        fetch_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench for pc_sequencer against an
// instruction-level reference model of the fetch/commit rules.
module tb_pc_sequencer;

  localparam int ACK_TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [3:0]  pc_control;
  logic        zero;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        illegal_err;
  logic        misalign_err;
  logic        fetch_timeout;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_pc;
  logic        m_ill, m_mis, m_to;

  pc_sequencer #(.RESET_PC(32'h0), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc_control    (pc_control),
    .zero          (zero),
    .rs_data       (rs_data),
    .pc            (pc),
    .link_addr     (link_addr),
    .illegal_err   (illegal_err),
    .misalign_err  (misalign_err),
    .fetch_timeout (fetch_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] iw,
                                             input logic [3:0] ctl, input logic z,
                                             input logic [31:0] rs);
    logic [31:0] pc4;
    logic [31:0] bt;
    shortint     imm;
    int          off;
    pc4 = cur + 32'd4;
    imm = iw[15:0];
    off = imm;
    bt  = pc4 + 32'(off * 4);
    case (ctl)
      4'd0:       return pc4;
      4'd1, 4'd3: return (pc4 & 32'hF000_0000) | ((iw & 32'h03FF_FFFF) * 4);
      4'd2, 4'd4: return rs & 32'hFFFF_FFFC;
      4'd5:       return z ? bt : pc4;
      4'd6:       return z ? pc4 : bt;
      default:    return pc4;
    endcase
  endfunction

  task automatic model_reset();
    m_pc  = 32'h0;
    m_ill = 1'b0;
    m_mis = 1'b0;
    m_to  = 1'b0;
  endtask

  // Entered and left at a negedge inside a FETCH cycle with the request up.
  task automatic do_instr(input logic [31:0] iw, input int delay, input logic [3:0] ctl,
                          input logic z, input logic [31:0] rs);
    int cnt;
    cnt = 0;
    check("entry_req", imem_req, 1);
    check("entry_addr", imem_addr, m_pc);
    for (int i = 0; i < delay; i++) begin
      check("req_hold", imem_req, 1);
      check("addr_hold", imem_addr, m_pc);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      cnt++;
      if (cnt == ACK_TO) begin
        m_to = 1'b1;
        check("retry_req", imem_req, 0);
        check("fetch_timeout", fetch_timeout, m_to);
        check("retry_valid", instr_valid, 0);
        imem_ack   = 1'b1;
        imem_rdata = $urandom;
        @(negedge clk);
        imem_ack = 1'b0;
        check("reissue_req", imem_req, 1);
        check("reissue_addr", imem_addr, m_pc);
        cnt = 0;
      end
    end
    imem_ack   = 1'b1;
    imem_rdata = iw;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check("exec_valid", instr_valid, 1);
    check("exec_instr", instr, iw);
    check("exec_pc", pc, m_pc);
    check("link_addr", link_addr, m_pc + 32'd4);
    pc_control = ctl;
    zero       = z;
    rs_data    = rs;
    @(negedge clk);
    if (ctl > 4'd6) m_ill = 1'b1;
    if ((ctl == 4'd2 || ctl == 4'd4) && rs[1:0] != 2'b00) m_mis = 1'b1;
    m_pc = model_next(m_pc, iw, ctl, z, rs);
    pc_control = $urandom;
    zero       = $urandom;
    rs_data    = $urandom;
    check("post_valid", instr_valid, 0);
    check("next_pc", pc, m_pc);
    check("next_addr", imem_addr, m_pc);
    check("illegal_err", illegal_err, m_ill);
    check("misalign_err", misalign_err, m_mis);
    check("fetch_timeout_st", fetch_timeout, m_to);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, pc, 32'h0);
    check({tag, "_req"}, imem_req, 0);
    check({tag, "_valid"}, instr_valid, 0);
    check({tag, "_instr"}, instr, 32'h0);
    check({tag, "_flags"}, {29'b0, illegal_err, misalign_err, fetch_timeout}, 32'h0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 32'h0);
  endtask

  initial begin
    rst        = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    pc_control = 4'd0;
    zero       = 1'b0;
    rs_data    = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    release_reset();

    do_instr(32'h2009_0005, 0, 4'd0, 1'b0, 32'h0);
    check("seq_pc", pc, 32'h4);
    do_instr(32'h0800_0004, 0, 4'd1, 1'b0, 32'h0);
    check("j_pc", pc, 32'h10);
    do_instr(32'h1000_FFFC, 0, 4'd5, 1'b1, 32'h0);
    check("beq_taken", pc, 32'h4);
    do_instr(32'h0800_0004, 1, 4'd1, 1'b0, 32'h0);
    do_instr(32'h1000_FFFC, 0, 4'd5, 1'b0, 32'h0);
    check("beq_not", pc, 32'h14);
    do_instr(32'h0800_0004, 0, 4'd1, 1'b0, 32'h0);
    do_instr(32'h1400_FFFC, 2, 4'd6, 1'b0, 32'h0);
    check("bne_taken", pc, 32'h4);
    do_instr(32'h0800_0004, 0, 4'd1, 1'b0, 32'h0);
    do_instr(32'h1400_FFFC, 0, 4'd6, 1'b1, 32'h0);
    check("bne_not", pc, 32'h14);
    do_instr(32'h0810_0002, 0, 4'd1, 1'b0, 32'h0);
    check("jal_start", pc, 32'h0040_0008);
    do_instr(32'h0C10_0010, 0, 4'd3, 1'b0, 32'h0);
    check("jal_pc", pc, 32'h0040_0040);
    check("flags_clear", {30'b0, illegal_err, misalign_err}, 32'h0);
    do_instr(32'h0000_0008, 0, 4'd2, 1'b0, 32'h0000_0102);
    check("jr_pc", pc, 32'h100);
    check("jr_misalign", misalign_err, 1);
    check("ill_before", illegal_err, 0);
    do_instr(32'h0000_0000, 0, 4'd9, 1'b0, 32'h0);
    check("ill_pc", pc, 32'h104);
    check("ill_flag", illegal_err, 1);
    do_instr(32'h0000_0008, 0, 4'd2, 1'b0, 32'hFFFF_FFFC);
    do_instr(32'h0000_0000, 0, 4'd0, 1'b0, 32'h0);
    check("wrap_pc", pc, 32'h0);
    check("to_before", fetch_timeout, 0);
    do_instr(32'h2009_0001, ACK_TO, 4'd0, 1'b0, 32'h0);
    check("to_flag", fetch_timeout, 1);

    for (int k = 0; k < 40; k++) begin
      logic [31:0] iw;
      logic [3:0]  ctl;
      int          dly;
      iw  = $urandom;
      ctl = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
      dly = ($urandom_range(0, 9) == 0) ? $urandom_range(ACK_TO, ACK_TO + 4) : $urandom_range(0, 3);
      do_instr(iw, dly, ctl, 1'($urandom), $urandom);
    end

    // Reset in the middle of a fetch wait.
    imem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    check_reset_state("fetch_rst");
    release_reset();
    do_instr(32'h2009_0005, 1, 4'd0, 1'b0, 32'h0);

    // Reset while an instruction is in its commit cycle.
    imem_ack   = 1'b1;
    imem_rdata = 32'h0800_0100;
    @(negedge clk);
    imem_ack = 1'b0;
    check("mid_exec_valid", instr_valid, 1);
    rst = 1'b0;
    #1;
    model_reset();
    check_reset_state("exec_rst");
    release_reset();
    do_instr(32'h2009_0007, 0, 4'd0, 1'b0, 32'h0);
    check("after_rst_pc", pc, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
